nibble_packer_4in: RTL and testbench

NIBBLE_PACKER_4IN -- requirements
Module: nibble_packer_4in

---
 rtl/nibble_packer_4in_pkg.sv | 25 ++
 rtl/nibble_packer_4in_word_hold_reg.sv | 54 +++++
 rtl/nibble_packer_4in.sv | 98 +++++++++
 tb/tb_nibble_packer_4in.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/nibble_packer_4in_pkg.sv
// nibble_packer_4in_pkg
//   Shared nibble/word geometry used by the nibble packer and by the
//   nibble_mayor_4in consumer. It also holds a helper that drops a nibble into
//   its lane of a word.
//   No ports (package).
package nibble_packer_4in_pkg;

    localparam int unsigned NIBBLE_W         = 4;
    localparam int unsigned NIBBLES_PER_WORD = 4;
    localparam int unsigned WORD_W           = NIBBLE_W * NIBBLES_PER_WORD;
    localparam int unsigned CNT_W            = 2;

    // Lane k occupies bits [4k+3:4k]. Lane 0 is filled first.
    function automatic logic [WORD_W-1:0] insert_nibble(
        input logic [WORD_W-1:0]   word,
        input logic [CNT_W-1:0]    lane,
        input logic [NIBBLE_W-1:0] nib
    );
        logic [WORD_W-1:0] w;
        w = word;
        w[32'(lane)*NIBBLE_W +: NIBBLE_W] = nib;
        return w;
    endfunction

endpackage

// File: rtl/nibble_packer_4in_word_hold_reg.sv
// word_hold_reg
//   A 16-bit valid/ready holding register with a two-state EMPTY/FULL FSM.
//   A load always wins. The parent only asserts load_en when the register is
//   empty or is draining in the same cycle.
//   Ports:
//     clk, rst     : clock and synchronous active-high reset
//     load_en      : capture load_data this cycle
//     load_data    : word to capture
//     out_ready    : the consumer takes the held word this cycle
//     out_valid    : a word is held
//     out_data     : the held word; stable while out_valid=1 and out_ready=0
module word_hold_reg
    import nibble_packer_4in_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [WORD_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [WORD_W-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load_en) begin
            state_d = ST_FULL;
            data_d  = load_data;
        end else if (state_q == ST_FULL && out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = (state_q == ST_FULL);
    assign out_data  = data_q;

endmodule

// File: rtl/nibble_packer_4in.sv
// nibble_packer_4in
//   Packs a stream of 4-bit nibbles into 16-bit words. The first nibble of a
//   word goes to [3:0]. FLUSH closes a partial word early and zero-pads it.
//   Buffering is one held word plus up to three assembling nibbles.
//   Ports:
//     CLK, RESET    : clock and synchronous active-high reset
//     NIBBLE_IN     : upstream nibble
//     NIBBLE_VALID  : NIBBLE_IN is valid
//     NIBBLE_READY  : a nibble can be accepted this cycle
//     FLUSH         : close the partial word now, zero-padding the rest
//     NIBBLES       : packed output word
//     WORD_VALID    : NIBBLES holds a complete word
//     WORD_READY    : the consumer takes the word this cycle
module nibble_packer_4in
    import nibble_packer_4in_pkg::*;
(
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NIBBLE_W-1:0] NIBBLE_IN,
    input  logic                NIBBLE_VALID,
    output logic                NIBBLE_READY,
    input  logic                FLUSH,
    output logic [WORD_W-1:0]   NIBBLES,
    output logic                WORD_VALID,
    input  logic                WORD_READY
);

    logic [CNT_W-1:0]  count_q, count_d;
    logic [WORD_W-1:0] asm_q, asm_d;
    logic              flush_pend_q, flush_pend_d;

    logic              word_valid;
    logic [WORD_W-1:0] nibbles;
    logic              can_load, nibble_ready, nib_xfer, last_nib;
    logic              has_data, flush_req, load;
    logic [WORD_W-1:0] asm_merged;

    always_comb begin
        // The holding register can take a new word if it is empty or is
        // being drained this cycle.
        can_load     = !word_valid || WORD_READY;
        nibble_ready = (count_q != 2'd3) || can_load;
        nib_xfer     = NIBBLE_VALID && nibble_ready;
        last_nib     = nib_xfer && (count_q == 2'd3);
        asm_merged   = nib_xfer ? insert_nibble(asm_q, count_q, NIBBLE_IN) : asm_q;
        has_data     = nib_xfer || (count_q != '0);
        flush_req    = FLUSH || flush_pend_q;

        // The count wraps 3->0 on its own when the 4th nibble is taken.
        count_d      = count_q + {1'b0, nib_xfer};
        asm_d        = asm_merged;
        flush_pend_d = 1'b0;
        load         = 1'b0;

        if (last_nib) begin
            // A full word already satisfies any flush, pending or not.
            load  = 1'b1;
            asm_d = '0;
        end else if (flush_req && has_data) begin
            if (can_load) begin
                load    = 1'b1;
                asm_d   = '0;
                count_d = '0;
            end else begin
                // Keep the flush pending. Nibbles that arrive meanwhile
                // become part of the partial word it will close.
                flush_pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            count_q      <= '0;
            asm_q        <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            asm_q        <= asm_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    word_hold_reg u_hold (
        .clk       (CLK),
        .rst       (RESET),
        .load_en   (load),
        .load_data (asm_merged),
        .out_ready (WORD_READY),
        .out_valid (word_valid),
        .out_data  (nibbles)
    );

    assign NIBBLE_READY = nibble_ready;
    assign WORD_VALID   = word_valid;
    assign NIBBLES      = nibbles;

endmodule

// File: tb/tb_nibble_packer_4in.sv
module tb_nibble_packer_4in;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  NIBBLE_IN;
    logic        NIBBLE_VALID;
    logic        NIBBLE_READY;
    logic        FLUSH;
    logic [15:0] NIBBLES;
    logic        WORD_VALID;
    logic        WORD_READY;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    // Reference model state
    logic [15:0] sb_q[$];
    int          m_cnt;
    logic [15:0] m_word;
    bit          m_full;
    bit          m_pend;

    always #5 CLK = ~CLK;

    nibble_packer_4in dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .NIBBLE_IN    (NIBBLE_IN),
        .NIBBLE_VALID (NIBBLE_VALID),
        .NIBBLE_READY (NIBBLE_READY),
        .FLUSH        (FLUSH),
        .NIBBLES      (NIBBLES),
        .WORD_VALID   (WORD_VALID),
        .WORD_READY   (WORD_READY)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        sb_q.delete();
        m_cnt  = 0;
        m_word = '0;
        m_full = 0;
        m_pend = 0;
    endtask

    // One cycle: drive the inputs, check the outputs against the model, advance the model, and clock.
    // On entry and exit the time is just after a falling edge.
    task automatic step(input bit v, input logic [3:0] nib, input bit fl, input bit wr);
        bit m_ready, xfer, free, load;
        NIBBLE_VALID = v;
        NIBBLE_IN    = nib;
        FLUSH        = fl;
        WORD_READY   = wr;
        #1;
        m_ready = !(m_cnt == 3 && m_full && !wr);
        check_eq("nibble_ready", NIBBLE_READY, m_ready);
        check_eq("word_valid", WORD_VALID, m_full);
        if (WORD_VALID) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_nonempty", 0, 1);
            end else begin
                check_eq("word", NIBBLES, sb_q[0]);
                if (wr) void'(sb_q.pop_front());
            end
        end
        xfer = v && m_ready;
        free = !m_full || wr;
        load = 0;
        if (xfer) begin
            m_word[m_cnt*4 +: 4] = nib;
            m_cnt++;
        end
        if (m_cnt == 4) begin
            load = 1;
        end else if ((fl || m_pend) && m_cnt > 0) begin
            if (free) load = 1;
            else m_pend = 1;
        end else begin
            m_pend = 0;
        end
        if (load) begin
            sb_q.push_back(m_word);
            m_full = 1;
            m_cnt  = 0;
            m_word = '0;
            m_pend = 0;
        end else if (m_full && wr) begin
            m_full = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RESET        = 1'b1;
        NIBBLE_VALID = 1'b1;
        NIBBLE_IN    = 4'hF;
        FLUSH        = 1'b1;
        WORD_READY   = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
        NIBBLE_VALID = 1'b0;
        FLUSH = 1'b0;
        #1;
        check_eq("rst_word_valid", WORD_VALID, 0);
        check_eq("rst_nibbles", NIBBLES, 16'h0000);
        check_eq("rst_nibble_ready", NIBBLE_READY, 1);
        model_clear();
    endtask

    initial begin
        RESET = 1'b1;
        NIBBLE_VALID = 1'b0;
        NIBBLE_IN = '0;
        FLUSH = 1'b0;
        WORD_READY = 1'b0;
        model_clear();
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        do_reset();

        // Basic packing: word appears one cycle after the 4th nibble, for one cycle
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 1);
        check_eq("t31_valid", WORD_VALID, 1);
        check_eq("t31_word", NIBBLES, 16'h4321);
        step(0, 0, 0, 1);
        check_eq("t31_one_cycle", WORD_VALID, 0);

        // Backpressure: A..F,7 with WORD_READY low
        step(1, 4'hA, 0, 0); step(1, 4'hB, 0, 0); step(1, 4'hC, 0, 0); step(1, 4'hD, 0, 0);
        step(1, 4'hE, 0, 0); step(1, 4'hF, 0, 0); step(1, 4'h7, 0, 0);
        check_eq("t32_held", NIBBLES, 16'hDCBA);
        check_eq("t32_ready_low", NIBBLE_READY, 0);
        step(1, 4'h9, 0, 0);            // refused; must not appear anywhere
        check_eq("t32_still_held", NIBBLES, 16'hDCBA);
        step(0, 0, 0, 1);               // DCBA drains
        check_eq("t32_drained", WORD_VALID, 0);
        step(1, 4'h8, 0, 1);
        check_eq("t32_second", NIBBLES, 16'h87FE);
        step(0, 0, 0, 1);

        // Flush of a partial word
        step(1, 4'h5, 0, 1); step(1, 4'h6, 0, 1); step(0, 0, 1, 1);
        check_eq("t33_flush", NIBBLES, 16'h0065);
        check_eq("t33_flush_v", WORD_VALID, 1);
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 1);
        check_eq("t33_next", NIBBLES, 16'h4321);
        step(0, 0, 0, 1);

        // Flush stalled behind a held word
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0);
        step(1, 4'h9, 0, 0); step(1, 4'hA, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        check_eq("t34_stall", NIBBLES, 16'h4321);
        step(0, 0, 0, 1);
        check_eq("t34_loaded", NIBBLES, 16'h00A9);
        check_eq("t34_loaded_v", WORD_VALID, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        check_eq("t34_empty_flush", WORD_VALID, 0);

        // Reset with data in flight
        for (int i = 1; i <= 4; i++) step(1, 4'(i), 0, 0);
        step(1, 4'hB, 0, 0); step(1, 4'hC, 0, 0);
        do_reset();
        step(1, 4'h1, 0, 1); step(1, 4'h2, 0, 1); step(1, 4'h3, 0, 1); step(1, 4'h4, 0, 1);
        check_eq("t35_clean", NIBBLES, 16'h4321);
        step(0, 0, 0, 1);

        // Random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 4) != 0, 4'($urandom), ($urandom % 8) == 0, ($urandom % 3) != 0);
        end
        repeat (6) step(0, 0, 0, 1);
        check_eq("sb_drained", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
